// File: rtl/syscall_pkg.sv
// Shared definitions for the console syscall unit: syscall codes, FSM
// states, ASCII constants, the powers-of-ten table and small helpers.
// No ports (package).
package syscall_pkg;

  localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
  localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
  localparam logic [31:0] SYS_EXIT       = 32'd10;
  localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    CHAR_EMIT = 4'd1,
    STR_FETCH = 4'd2,
    STR_WAIT  = 4'd3,
    STR_EMIT  = 4'd4,
    INT_SIGN  = 4'd5,
    INT_DIGIT = 4'd6,
    INT_EMIT  = 4'd7,
    HALTED    = 4'd8
  } state_e;

  // Entry k holds 10^k.
  localparam logic [9:0][31:0] POW10_TAB = {
    32'd1000000000, 32'd100000000, 32'd10000000, 32'd1000000, 32'd100000,
    32'd10000,      32'd1000,      32'd100,      32'd10,      32'd1
  };

  function automatic logic [31:0] pow10(input logic [3:0] k);
    logic [31:0] p;
    if (k > 4'd9) p = 32'd0;
    else          p = POW10_TAB[k];
    return p;
  endfunction

  function automatic logic is_known_code(input logic [31:0] c);
    return (c == SYS_PRINT_INT) || (c == SYS_PRINT_STR) ||
           (c == SYS_EXIT)      || (c == SYS_PRINT_CHAR);
  endfunction

  // Byte lane for a byte offset; big-endian puts offset 0 in bits 31:24.
  function automatic logic [7:0] pick_byte(input logic [31:0] w,
                                           input logic [1:0]  off,
                                           input logic        be);
    logic [1:0] lane;
    logic [7:0] b;
    lane = be ? (2'd3 - off) : off;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/syscall_unit_if.sv
// Bundle of the syscall unit's core-side, memory-side and console-side
// signals.
//   slave  : the syscall unit (takes requests, issues reads, emits bytes)
//   master : the environment (core, memory and console sink)
interface syscall_unit_if;
  logic        syscall_req;
  logic [31:0] sys_call_reg;
  logic [31:0] std_out_address;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rd_data;
  logic        mem_rd_valid;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        halted;
  logic        err;

  modport slave (
    input  syscall_req, sys_call_reg, std_out_address,
    input  mem_rd_data, mem_rd_valid, out_ready,
    output mem_rd_en, mem_addr, out_data, out_valid, busy, halted, err
  );

  modport master (
    output syscall_req, sys_call_reg, std_out_address,
    output mem_rd_data, mem_rd_valid, out_ready,
    input  mem_rd_en, mem_addr, out_data, out_valid, busy, halted, err
  );
endinterface

// File: rtl/syscall_unit_dec_digit_gen.sv
// Decimal digit generator for print_int.
//   clk, reset  : clock, synchronous active-high reset
//   start       : load value and begin at the 10^9 position
//   value       : unsigned magnitude to convert
//   next        : current digit consumed, advance to the next power
//   digit       : current decimal digit (0..9)
//   digit_valid : digit ready to print (leading zeros never show up here)
//   last        : current digit is the units digit
module dec_digit_gen
  import syscall_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] value,
  input  logic        next,
  output logic [3:0]  digit,
  output logic        digit_valid,
  output logic        last
);

  logic [31:0] mag_r;
  logic [3:0]  k_r;
  logic [3:0]  digit_r;
  logic        run_r;
  logic        lead_r;
  logic        active_r;
  logic [31:0] pow_s;
  logic        lz_s;

  assign pow_s = pow10(k_r);
  // Leading zero: nothing printed yet and this is not the units digit.
  assign lz_s  = lead_r && (digit_r == 4'd0) && (k_r != 4'd0);

  // Repeated subtraction, one per cycle; leading zeros are skipped internally.
  always_ff @(posedge clk) begin
    if (reset) begin
      mag_r    <= 32'd0;
      k_r      <= 4'd0;
      digit_r  <= 4'd0;
      run_r    <= 1'b0;
      lead_r   <= 1'b0;
      active_r <= 1'b0;
    end else if (start) begin
      mag_r    <= value;
      k_r      <= 4'd9;
      digit_r  <= 4'd0;
      run_r    <= 1'b1;
      lead_r   <= 1'b1;
      active_r <= 1'b1;
    end else if (active_r) begin
      if (run_r) begin
        if (mag_r >= pow_s) begin
          mag_r   <= mag_r - pow_s;
          digit_r <= digit_r + 4'd1;
        end else begin
          run_r <= 1'b0;
        end
      end else if (lz_s) begin
        k_r     <= k_r - 4'd1;
        digit_r <= 4'd0;
        run_r   <= 1'b1;
      end else if (next) begin
        lead_r <= 1'b0;
        if (k_r == 4'd0) begin
          active_r <= 1'b0;
        end else begin
          k_r     <= k_r - 4'd1;
          digit_r <= 4'd0;
          run_r   <= 1'b1;
        end
      end
    end
  end

  assign digit       = digit_r;
  assign digit_valid = active_r && !run_r && !lz_s;
  assign last        = (k_r == 4'd0);

endmodule

// File: rtl/syscall_unit.sv
// SPIM-style console syscall executor sitting beside the register file.
//   clk, reset : clock, synchronous active-high reset
//   bus        : syscall_unit_if.slave
//     syscall_req/sys_call_reg/std_out_address : request, $v0 code, $a0 arg
//     mem_rd_en/mem_addr/mem_rd_data/mem_rd_valid : word read port
//     out_data/out_valid/out_ready : console byte stream (valid/ready)
//     busy (core stall), halted (sticky exit), err (sticky error)
module syscall_unit
  import syscall_pkg::*;
#(
  parameter int MAX_STR_LEN = 256,
  parameter bit BIG_ENDIAN  = 1'b1
)(
  input  logic           clk,
  input  logic           reset,
  syscall_unit_if.slave  bus
);

  localparam logic [31:0] MAX_LEN_C = 32'(MAX_STR_LEN);

  state_e      state_r, state_s;
  logic [31:0] arg_r, ptr_r, word_r, cnt_r;
  logic        halted_r, err_r;
  logic [7:0]  byte_s, out_data_s;
  logic        out_valid_s, mem_rd_en_s;
  logic        nul_s, xfer_s, str_full_s;
  logic        gen_start_s, gen_next_s, digit_valid_s, digit_last_s;
  logic [3:0]  digit_s;
  logic [31:0] mag_in_s;

  assign byte_s      = pick_byte(word_r, ptr_r[1:0], BIG_ENDIAN);
  assign nul_s       = (byte_s == 8'h00);
  assign xfer_s      = out_valid_s & bus.out_ready;
  assign str_full_s  = ((cnt_r + 32'd1) == MAX_LEN_C);
  // Negation of 0x80000000 stays 0x80000000, read as unsigned 2147483648.
  assign mag_in_s    = arg_r[31] ? (~arg_r + 32'd1) : arg_r;
  assign gen_start_s = (state_r == INT_SIGN) && (state_s == INT_DIGIT);
  assign gen_next_s  = (state_r == INT_EMIT) && bus.out_ready;

  dec_digit_gen u_digits (
    .clk         (clk),
    .reset       (reset),
    .start       (gen_start_s),
    .value       (mag_in_s),
    .next        (gen_next_s),
    .digit       (digit_s),
    .digit_valid (digit_valid_s),
    .last        (digit_last_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.syscall_req) begin
          case (bus.sys_call_reg)
            SYS_PRINT_INT:  state_s = INT_SIGN;
            SYS_PRINT_STR:  state_s = STR_FETCH;
            SYS_EXIT:       state_s = HALTED;
            SYS_PRINT_CHAR: state_s = CHAR_EMIT;
            default:        state_s = IDLE;
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      CHAR_EMIT: begin
        if (bus.out_ready) state_s = IDLE;
        else               state_s = CHAR_EMIT;
      end
      STR_FETCH: state_s = STR_WAIT;
      STR_WAIT: begin
        if (bus.mem_rd_valid) state_s = STR_EMIT;
        else                  state_s = STR_WAIT;
      end
      STR_EMIT: begin
        if (nul_s)                   state_s = IDLE;
        else if (!xfer_s)            state_s = STR_EMIT;
        else if (str_full_s)         state_s = IDLE;
        else if (ptr_r[1:0] == 2'd3) state_s = STR_FETCH;
        else                         state_s = STR_EMIT;
      end
      INT_SIGN: begin
        if (!arg_r[31] || bus.out_ready) state_s = INT_DIGIT;
        else                             state_s = INT_SIGN;
      end
      INT_DIGIT: begin
        if (digit_valid_s) state_s = INT_EMIT;
        else               state_s = INT_DIGIT;
      end
      INT_EMIT: begin
        if (!bus.out_ready)   state_s = INT_EMIT;
        else if (digit_last_s) state_s = IDLE;
        else                   state_s = INT_DIGIT;
      end
      HALTED:  state_s = HALTED;
      default: state_s = IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    out_valid_s = 1'b0;
    out_data_s  = 8'h00;
    mem_rd_en_s = 1'b0;
    case (state_r)
      CHAR_EMIT: begin
        out_valid_s = 1'b1;
        out_data_s  = arg_r[7:0];
      end
      STR_FETCH: mem_rd_en_s = 1'b1;
      STR_EMIT: begin
        out_valid_s = !nul_s;
        out_data_s  = byte_s;
      end
      INT_SIGN: begin
        out_valid_s = arg_r[31];
        out_data_s  = arg_r[31] ? ASCII_MINUS : 8'h00;
      end
      INT_EMIT: begin
        out_valid_s = 1'b1;
        out_data_s  = ASCII_ZERO + {4'd0, digit_s};
      end
      default: begin
        out_valid_s = 1'b0;
        out_data_s  = 8'h00;
        mem_rd_en_s = 1'b0;
      end
    endcase
  end

  // Operand capture, string pointer/word/count and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      arg_r    <= 32'd0;
      ptr_r    <= 32'd0;
      word_r   <= 32'd0;
      cnt_r    <= 32'd0;
      halted_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.syscall_req) begin
            arg_r <= bus.std_out_address;
            ptr_r <= bus.std_out_address;
            cnt_r <= 32'd0;
            if (bus.sys_call_reg == SYS_EXIT)      halted_r <= 1'b1;
            if (!is_known_code(bus.sys_call_reg)) err_r    <= 1'b1;
          end
        end
        STR_WAIT: begin
          if (bus.mem_rd_valid) word_r <= bus.mem_rd_data;
        end
        STR_EMIT: begin
          if (xfer_s) begin
            ptr_r <= ptr_r + 32'd1;
            cnt_r <= cnt_r + 32'd1;
            if (str_full_s) err_r <= 1'b1;
          end
        end
        default: begin
          arg_r <= arg_r;
        end
      endcase
    end
  end

  assign bus.mem_rd_en = mem_rd_en_s;
  assign bus.mem_addr  = {ptr_r[31:2], 2'b00};
  assign bus.out_data  = out_data_s;
  assign bus.out_valid = out_valid_s;
  assign bus.busy      = bus.syscall_req || ((state_r != IDLE) && (state_r != HALTED));
  assign bus.halted    = halted_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_syscall_unit.sv
// Self-checking bench for syscall_unit: expected console text is derived
// from memory contents and $sformatf, compared byte by byte as transfers occur.
module tb_syscall_unit;
  localparam bit BE = 1'b1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  syscall_unit_if bus();
  syscall_unit #(.MAX_STR_LEN(256), .BIG_ENDIAN(BE)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int checks = 0, errors = 0;
  logic [31:0] mem [logic [31:0]];
  logic [7:0]  exp_q[$];
  logic [31:0] exp_rd[$], rd_log[$];
  string got_str;
  int busy_cnt = 0, rd_pulses = 0;
  bit rand_ready = 1'b0, force_low = 1'b0;
  int lat_max = 1;
  bit err_exp = 1'b0, halted_exp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] wa, w;
    int sh;
    wa = {a[31:2], 2'b00};
    w  = mem.exists(wa) ? mem[wa] : 32'h0;
    sh = BE ? 8 * (3 - int'(a[1:0])) : 8 * int'(a[1:0]);
    return 8'((w >> sh) & 32'hFF);
  endfunction

  task automatic put_byte(input logic [31:0] a, input logic [7:0] b);
    logic [31:0] wa, w;
    int sh;
    wa = {a[31:2], 2'b00};
    w  = mem.exists(wa) ? mem[wa] : 32'h0;
    sh = BE ? 8 * (3 - int'(a[1:0])) : 8 * int'(a[1:0]);
    mem[wa] = (w & ~(32'hFF << sh)) | (32'(b) << sh);
  endtask

  task automatic put_str(input logic [31:0] a, input string s);
    for (int i = 0; i < s.len(); i++) put_byte(a + 32'(i), s[i]);
    put_byte(a + 32'(s.len()), 8'h00);
  endtask

  // Model the syscall, then drive a one-cycle request with garbage afterwards.
  task automatic issue(input logic [31:0] code, input logic [31:0] a0);
    string s;
    int n, nw;
    logic [31:0] last;
    got_str = ""; rd_log.delete(); exp_rd.delete(); busy_cnt = 0; rd_pulses = 0;
    if (!halted_exp) begin
      case (code)
        32'd11: exp_q.push_back(a0[7:0]);
        32'd1: begin
          s = $sformatf("%0d", $signed(a0));
          for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        end
        32'd4: begin
          last = a0;
          for (n = 0; n < 256; n++) begin
            last = a0 + 32'(n);
            if (mem_byte(last) == 8'h00) break;
            exp_q.push_back(mem_byte(last));
          end
          if (n == 256) err_exp = 1'b1;
          nw = int'((last >> 2) - (a0 >> 2)) + 1;
          for (int i = 0; i < nw; i++) exp_rd.push_back({a0[31:2], 2'b00} + 32'(4 * i));
        end
        32'd10: halted_exp = 1'b1;
        default: err_exp = 1'b1;
      endcase
    end
    @(posedge clk); #1;
    bus.syscall_req = 1'b1; bus.sys_call_reg = code; bus.std_out_address = a0;
    @(posedge clk); #1;
    bus.syscall_req = 1'b0; bus.sys_call_reg = $urandom; bus.std_out_address = $urandom;
  endtask

  task automatic finish(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (bus.busy && t < 5000) begin @(negedge clk); t++; end
    chk({name, "_timeout"}, 32'(t < 5000), 32'd1);
    repeat (2) @(negedge clk);
    chk({name, "_leftover"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    chk({name, "_reads"}, 32'(rd_pulses), 32'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
      chk({name, "_rd_addr"}, rd_log[i], exp_rd[i]);
    chk({name, "_err"}, 32'(bus.err), 32'(err_exp));
    chk({name, "_halted"}, 32'(bus.halted), 32'(halted_exp));
    chk({name, "_busy_end"}, 32'(bus.busy), 32'd0);
  endtask

  // Console sink.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = force_low ? 1'b0 : (rand_ready ? ($urandom_range(3, 0) != 0) : 1'b1);
    end
  end

  // Memory responder with random latency of 1..lat_max cycles.
  initial begin
    logic [31:0] a;
    int lat;
    bus.mem_rd_valid = 1'b0; bus.mem_rd_data = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.mem_rd_en && !reset) begin
        a = bus.mem_addr;
        rd_log.push_back(a);
        lat = int'($urandom_range(lat_max, 1));
        @(posedge clk);
        repeat (lat - 1) @(posedge clk);
        #1;
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = mem.exists(a) ? mem[a] : 32'h0;
        @(posedge clk); #1;
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = $urandom;
      end
    end
  end

  // Compare process: every transfer against the model, plus hold stability.
  initial begin
    bit pend;
    logic [7:0] pend_data, e;
    pend = 1'b0; pend_data = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 1'b0;
      end else begin
        if (bus.busy) busy_cnt++;
        if (bus.mem_rd_en) rd_pulses++;
        if (pend) begin
          chk("hold_valid", 32'(bus.out_valid), 32'd1);
          chk("hold_data", 32'(bus.out_data), 32'(pend_data));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_byte", 32'(bus.out_data), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("byte", 32'(bus.out_data), 32'(e));
          end
          got_str = $sformatf("%s%c", got_str, bus.out_data);
          pend = 1'b0;
        end else if (bus.out_valid) begin
          pend = 1'b1; pend_data = bus.out_data;
        end else begin
          pend = 1'b0;
        end
      end
    end
  end

  logic [31:0] int_a [3] = '{32'hFFFF_FECF, 32'h0000_0000, 32'h8000_0000};
  string       int_s [3] = '{"-305", "0", "-2147483648"};

  initial begin
    int t, r, len;
    logic [31:0] code, a0, base;
    bus.syscall_req = 1'b0; bus.sys_call_reg = 32'h0; bus.std_out_address = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    issue(32'd11, 32'h41); finish("char");
    chk("char_busy_cycles", 32'(busy_cnt), 32'd2);
    chk_str("char_text", got_str, "A");

    mem[32'h100] = 32'h4869_0000;
    issue(32'd4, 32'h100); finish("str_hi");
    chk_str("str_hi_text", got_str, "Hi");

    mem[32'h100] = 32'h0000_0041; mem[32'h104] = 32'h4200_0000;
    issue(32'd4, 32'h103); finish("str_ab");
    chk_str("str_ab_text", got_str, "AB");

    for (int i = 0; i < 3; i++) begin
      issue(32'd1, int_a[i]); finish("int");
      chk_str("int_text", got_str, int_s[i]);
    end

    // Sink stalls five cycles in the middle of a string.
    put_str(32'h201, "Hello, world");
    issue(32'd4, 32'h201);
    t = 0;
    do begin @(negedge clk); t++; end while (!(bus.out_valid && bus.out_ready) && t < 200);
    force_low = 1'b1;
    repeat (5) @(negedge clk);
    force_low = 1'b0;
    finish("hold");
    chk_str("hold_text", got_str, "Hello, world");

    // Reset while waiting for read data.
    put_str(32'h300, "XYZ");
    lat_max = 4;
    issue(32'd4, 32'h300);
    t = 0;
    while (!bus.mem_rd_en && t < 50) begin @(negedge clk); t++; end
    chk("rst_mid_seen_read", 32'(bus.mem_rd_en), 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    exp_q.delete(); err_exp = 1'b0; halted_exp = 1'b0;
    repeat (8) @(negedge clk);
    lat_max = 1;

    // No NUL within the byte limit.
    for (int i = 0; i < 300; i++) put_byte(32'h1000 + 32'(i), 8'($urandom_range(255, 1)));
    issue(32'd4, 32'h1000); finish("trunc");
    chk("trunc_len", 32'(got_str.len()), 32'd256);

    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    err_exp = 1'b0;
    issue(32'd7, 32'h0); finish("bad_code");
    chk("bad_code_len", 32'(got_str.len()), 32'd0);

    rand_ready = 1'b1; lat_max = 4;
    for (int it = 0; it < 40; it++) begin
      r = int'($urandom_range(9, 0));
      if (r <= 2) begin
        code = 32'd1;
        a0 = (r == 0) ? 32'($urandom_range(999, 0)) : $urandom;
      end else if (r <= 5) begin
        code = 32'd4;
        base = 32'h2000 + 32'($urandom_range(255, 0));
        len = int'($urandom_range(12, 0));
        for (int i = 0; i < len; i++) put_byte(base + 32'(i), 8'($urandom_range(255, 1)));
        put_byte(base + 32'(len), 8'h00);
        a0 = base;
      end else if (r <= 8) begin
        code = 32'd11; a0 = $urandom;
      end else begin
        code = 32'($urandom_range(200, 12)); a0 = $urandom;
      end
      issue(code, a0); finish("rand");
    end
    rand_ready = 1'b0;

    issue(32'd10, 32'h0); finish("exit");
    issue(32'd11, 32'h55); finish("after_exit");
    chk("after_exit_len", 32'(got_str.len()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/syscall_unit.md
Name: syscall_unit

Overview:
- Consumer end of the register file's syscall interface: takes the $v0 code (sys_call_reg) and $a0 argument (std_out_address), executes SPIM-style console syscalls, and streams ASCII bytes to a console sink.
- Sits beside the register file and data memory, and stalls the core while a syscall is in progress.
- Reads string bytes through a word-wide memory read port.

Parameters:
- MAX_STR_LEN, 256: byte limit for print_string if no NUL byte is found.
- BIG_ENDIAN, 1: 1 means byte offset 0 is data[31:24]; 0 means byte offset 0 is data[7:0].

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- syscall_req  in  1  one-cycle pulse from decode on SYSCALL.
- sys_call_reg  in  32  $v0, the syscall code.
- std_out_address  in  32  $a0, the argument.
- mem_rd_en  out  1  memory read request, one-cycle pulse.
- mem_addr  out  32  word-aligned read address.
- mem_rd_data  in  32  memory read data.
- mem_rd_valid  in  1  read data valid, arbitrary latency of 1 cycle or more.
- out_data  out  8  ASCII byte.
- out_valid  out  1  byte available.
- out_ready  in  1  sink accepts the byte.
- busy  out  1  stall request to the core.
- halted  out  1  exit executed; sticky.
- err  out  1  sticky: unknown code or string truncated.

Behaviour:
- Reset: all outputs are 0 and state is IDLE. Reset mid-operation aborts immediately, with no partial byte and no pending read. Reset is the only way to clear halted and err.
- busy is combinational: syscall_req OR (state not in {IDLE, HALTED}). The core holds its PC while busy is high.
- Operands are sampled into internal registers on the syscall_req cycle. Later changes to $v0/$a0 are ignored.
- Codes:
  - 1 print_int: a0 printed as signed decimal.
  - 4 print_string: NUL-terminated string at address a0.
  - 10 exit.
  - 11 print_char: a0[7:0].
  - Any other code: set err, return to IDLE next cycle, no output.
- States: IDLE, CHAR_EMIT, STR_FETCH, STR_WAIT, STR_EMIT, INT_SIGN, INT_DIGIT, INT_EMIT, HALTED.
- Output handshake:
  - A transfer occurs when out_valid and out_ready are both high.
  - out_data is stable while out_valid is high and out_ready is low.
  - out_valid never drops without a transfer, except on reset.
- print_char: CHAR_EMIT holds out_valid until transfer, then IDLE.
- print_string:
  - STR_FETCH pulses mem_rd_en with mem_addr = {ptr[31:2], 2'b00}, then goes to STR_WAIT.
  - STR_WAIT latches mem_rd_data on mem_rd_valid.
  - STR_EMIT selects the byte at ptr[1:0] per BIG_ENDIAN:
    - Byte 0x00: go to IDLE without emitting.
    - Otherwise: emit the byte; on transfer increment ptr and the byte count.
  - After an emitted byte, if ptr[1:0] has wrapped to 00, go to STR_FETCH. Otherwise stay in STR_EMIT and reuse the latched word (one read per word).
  - When the count reaches MAX_STR_LEN: set err, go to IDLE.
  - Unaligned start addresses are legal.
- print_int:
  - INT_SIGN: if a0[31] is set, emit '-' and set mag = two's-complement negation. 0x80000000 yields magnitude 2147483648 as unsigned.
  - INT_DIGIT: for power index k = 9 down to 0, repeatedly subtract 10^k from mag while mag >= 10^k, one subtraction per cycle, counting the digit (0..9).
  - INT_EMIT: emit '0'+digit unless it is a leading zero. k = 0 always emits, so value 0 prints "0".
  - Worst case is about 100 cycles plus handshake stalls.
- exit: go to HALTED and set halted. syscall_req is ignored while in HALTED.
- syscall_req while busy: ignored. The core guarantees this does not occur.

Decomposition:
- Shared package syscall_pkg contains:
  - codes SYS_PRINT_INT=1, SYS_PRINT_STR=4, SYS_EXIT=10, SYS_PRINT_CHAR=11
  - the state enum
  - ASCII_ZERO=8'h30 and ASCII_MINUS=8'h2D
  - a 10-entry powers-of-ten table, 32-bit each
- One sub-module, dec_digit_gen: owns mag, k, the subtractor and the leading-zero flag.
  - Interface: start, value, next, digit, digit_valid, last.

Test Plan:
- v0=11, a0=0x00000041, out_ready=1: one byte 0x41; busy high for 2 cycles; no memory reads.
- v0=4, a0=0x100, mem[0x100]=0x48690000, BIG_ENDIAN=1: bytes 'H','i'; exactly one read at 0x100; busy drops after the NUL.
- v0=4, a0=0x103, mem[0x100]=0x00000041, mem[0x104]=0x42000000: bytes 'A','B'; reads at 0x100 then 0x104.
- v0=1, a0=0xFFFFFECF (-305): "-305". a0=0: "0". a0=0x80000000: "-2147483648".
- out_ready held low 5 cycles mid-string: out_data stable, no byte lost or duplicated. Reset asserted during STR_WAIT: out_valid=0 and busy=0 the next cycle.
- v0=10: halted=1 and busy=0; a subsequent syscall_req has no effect. v0=7: err=1, no output.
